// File: rtl/tracker_pkg.sv
// Shared types and error arithmetic for the multi-axis tracker sequencer.
package tracker_pkg;

    // Operands are zero-extended to MAX_W bits before subtraction, so an
    // ERR_W-bit signed result holds exactly the same value as a W+1-bit one
    // for any W <= MAX_W.
    localparam int MAX_W = 32;
    localparam int ERR_W = MAX_W + 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EVAL,
        ST_MOVE,
        ST_SETTLE,
        ST_NEXT
    } trk_state_t;

    typedef enum logic [1:0] {
        DIR_NONE,
        DIR_POS,
        DIR_NEG
    } trk_dir_t;

    // a - b as a signed value; never wraps because both operands are non-negative.
    function automatic logic signed [ERR_W-1:0] signed_err(input logic [MAX_W-1:0] a,
                                                           input logic [MAX_W-1:0] b);
        return $signed({1'b0, a}) - $signed({1'b0, b});
    endfunction

    // Magnitude of a signed error; the most negative value maps to its true magnitude.
    function automatic logic [ERR_W-1:0] abs_err(input logic signed [ERR_W-1:0] e);
        return e[ERR_W-1] ? $unsigned(-e) : $unsigned(e);
    endfunction

endpackage

// File: rtl/multi_axis_tracker_ctrl_if.sv
// Front-end / motor-driver bundle of the tracker sequencer.
// There is no valid/ready handshake: every signal is a level, the front end
// updates inputs synchronously to clk and the sequencer samples them on every
// rising edge; outputs are registered and change only on rising edges.
interface multi_axis_tracker_ctrl_if #(
    parameter int N_AXES = 2,
    parameter int W      = 16
);
    localparam int AW = (N_AXES > 1) ? $clog2(N_AXES) : 1;

    logic                mode_manual;
    logic [N_AXES*W-1:0] sens_a;
    logic [N_AXES*W-1:0] sens_b;
    logic [N_AXES*W-1:0] pos_target;
    logic [N_AXES*W-1:0] pos_actual;
    logic [N_AXES-1:0]   mov_pos;
    logic [N_AXES-1:0]   mov_neg;
    logic [AW-1:0]       active_axis;
    logic [N_AXES-1:0]   axis_fault;
    logic                cycle_done;

    modport master (
        output mode_manual, sens_a, sens_b, pos_target, pos_actual,
        input  mov_pos, mov_neg, active_axis, axis_fault, cycle_done
    );

    modport slave (
        input  mode_manual, sens_a, sens_b, pos_target, pos_actual,
        output mov_pos, mov_neg, active_axis, axis_fault, cycle_done
    );
endinterface

// File: rtl/axis_err_calc.sv
// Error magnitude and drive direction of the selected axis, in either mode.
module axis_err_calc
    import tracker_pkg::*;
#(
    parameter int                N_AXES    = 2,
    parameter int                W         = 16,
    parameter int                HALF_TURN = 180,
    parameter logic [N_AXES-1:0] WRAP_MASK = '0,
    parameter int                AW        = (N_AXES > 1) ? $clog2(N_AXES) : 1
) (
    input  logic                mode_manual,
    input  logic [N_AXES*W-1:0] sens_a,
    input  logic [N_AXES*W-1:0] sens_b,
    input  logic [N_AXES*W-1:0] pos_target,
    input  logic [N_AXES*W-1:0] pos_actual,
    input  logic [AW-1:0]       sel,
    output logic [ERR_W-1:0]    mag,
    output trk_dir_t            dir
);
    localparam logic [ERR_W-1:0] HALF_V = ERR_W'(HALF_TURN);

    logic [W-1:0]             op_a;
    logic [W-1:0]             op_b;
    logic                     wrap;
    logic signed [ERR_W-1:0]  err;

    // Pick the selected axis operands for the current mode.
    always_comb begin
        op_a = '0;
        op_b = '0;
        wrap = 1'b0;
        for (int i = 0; i < N_AXES; i++) begin
            if (sel == AW'(i)) begin
                op_a = mode_manual ? pos_target[i*W +: W] : sens_a[i*W +: W];
                op_b = mode_manual ? pos_actual[i*W +: W] : sens_b[i*W +: W];
                wrap = mode_manual & WRAP_MASK[i];
            end
        end
    end

    // Signed error, magnitude and direction; rotary axes take the short way round.
    always_comb begin
        err = signed_err(MAX_W'(op_a), MAX_W'(op_b));
        mag = abs_err(err);
        if (err[ERR_W-1]) begin
            dir = DIR_NEG;
        end else if (err != '0) begin
            dir = DIR_POS;
        end else begin
            dir = DIR_NONE;
        end
        if (wrap && (mag > HALF_V)) begin
            dir = (dir == DIR_POS) ? DIR_NEG : DIR_POS;
        end
    end
endmodule

// File: rtl/multi_axis_tracker_ctrl.sv
// Round-robin motion sequencer: evaluates one axis at a time, moves it with
// hysteresis and a timeout, dwells to settle, then advances to the next axis.
module multi_axis_tracker_ctrl
    import tracker_pkg::*;
#(
    parameter int                N_AXES       = 2,
    parameter int                W            = 16,
    parameter int                TOL_START    = 5,
    parameter int                TOL_STOP     = 2,
    parameter int                HALF_TURN    = 180,
    parameter logic [N_AXES-1:0] WRAP_MASK    = '0,
    parameter int                SETTLE_CYC   = 1000,
    parameter int                MAX_MOVE_CYC = 2**20
) (
    input  logic                      clk,
    input  logic                      rst,
    multi_axis_tracker_ctrl_if.slave  bus,
    output trk_state_t                dbg_state
);
    localparam int AW  = (N_AXES > 1) ? $clog2(N_AXES) : 1;
    localparam int MCW = (MAX_MOVE_CYC > 1) ? $clog2(MAX_MOVE_CYC) : 1;
    localparam int SCW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [ERR_W-1:0] TOL_START_V = ERR_W'(TOL_START);
    localparam logic [ERR_W-1:0] TOL_STOP_V  = ERR_W'(TOL_STOP);

    trk_state_t        state_q, state_d;
    trk_dir_t          dir_q, dir_d;
    logic [AW-1:0]     a_q, a_d;
    logic [MCW-1:0]    move_cnt_q, move_cnt_d;
    logic [SCW-1:0]    settle_cnt_q, settle_cnt_d;
    logic [N_AXES-1:0] fault_q, fault_d;
    logic [N_AXES-1:0] mov_pos_q, mov_pos_d;
    logic [N_AXES-1:0] mov_neg_q, mov_neg_d;
    logic              done_q, done_d;
    logic              mode_q;
    logic [ERR_W-1:0]  mag;
    trk_dir_t          dir;

    axis_err_calc #(
        .N_AXES    (N_AXES),
        .W         (W),
        .HALF_TURN (HALF_TURN),
        .WRAP_MASK (WRAP_MASK),
        .AW        (AW)
    ) u_err (
        .mode_manual (bus.mode_manual),
        .sens_a      (bus.sens_a),
        .sens_b      (bus.sens_b),
        .pos_target  (bus.pos_target),
        .pos_actual  (bus.pos_actual),
        .sel         (a_q),
        .mag         (mag),
        .dir         (dir)
    );

    // Next state, counters, faults and the registered output values.
    always_comb begin
        state_d      = state_q;
        dir_d        = dir_q;
        a_d          = a_q;
        move_cnt_d   = move_cnt_q;
        settle_cnt_d = settle_cnt_q;
        fault_d      = fault_q;
        done_d       = 1'b0;
        mov_pos_d    = '0;
        mov_neg_d    = '0;

        case (state_q)
            ST_IDLE: begin
                state_d = ST_EVAL;
                a_d     = '0;
            end
            ST_EVAL: begin
                move_cnt_d   = '0;
                settle_cnt_d = '0;
                if (fault_q[a_q] || (mag <= TOL_START_V)) begin
                    state_d = ST_SETTLE;
                    dir_d   = DIR_NONE;
                end else begin
                    state_d = ST_MOVE;
                    dir_d   = dir;
                end
            end
            ST_MOVE: begin
                if (mag <= TOL_STOP_V) begin
                    state_d = ST_SETTLE;
                end else if (move_cnt_q == MCW'(MAX_MOVE_CYC - 1)) begin
                    fault_d[a_q] = 1'b1;
                    state_d      = ST_SETTLE;
                end else if (dir != dir_q) begin
                    // Overshoot: error sign no longer matches the drive direction.
                    state_d = ST_SETTLE;
                end else begin
                    move_cnt_d = move_cnt_q + 1'b1;
                end
                if (state_d == ST_SETTLE) begin
                    dir_d        = DIR_NONE;
                    settle_cnt_d = '0;
                end
            end
            ST_SETTLE: begin
                if (settle_cnt_q == SCW'(SETTLE_CYC - 1)) begin
                    state_d = ST_NEXT;
                end else begin
                    settle_cnt_d = settle_cnt_q + 1'b1;
                end
            end
            ST_NEXT: begin
                state_d = ST_EVAL;
                if (a_q == AW'(N_AXES - 1)) begin
                    a_d    = '0;
                    done_d = 1'b1;
                end else begin
                    a_d = a_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A mode change abandons the pass and restarts from axis 0; faults stay.
        if (mode_q != bus.mode_manual) begin
            state_d      = ST_EVAL;
            dir_d        = DIR_NONE;
            a_d          = '0;
            move_cnt_d   = '0;
            settle_cnt_d = '0;
            done_d       = 1'b0;
        end

        if (state_d == ST_MOVE) begin
            mov_pos_d[a_d] = (dir_d == DIR_POS);
            mov_neg_d[a_d] = (dir_d == DIR_NEG);
        end
    end

    // State, counters and all outputs are registered here.
    always_ff @(posedge clk) begin
        mode_q <= bus.mode_manual;
        if (rst) begin
            state_q      <= ST_IDLE;
            dir_q        <= DIR_NONE;
            a_q          <= '0;
            move_cnt_q   <= '0;
            settle_cnt_q <= '0;
            fault_q      <= '0;
            mov_pos_q    <= '0;
            mov_neg_q    <= '0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            dir_q        <= dir_d;
            a_q          <= a_d;
            move_cnt_q   <= move_cnt_d;
            settle_cnt_q <= settle_cnt_d;
            fault_q      <= fault_d;
            mov_pos_q    <= mov_pos_d;
            mov_neg_q    <= mov_neg_d;
            done_q       <= done_d;
        end
    end

    assign bus.mov_pos     = mov_pos_q;
    assign bus.mov_neg     = mov_neg_q;
    assign bus.active_axis = a_q;
    assign bus.axis_fault  = fault_q;
    assign bus.cycle_done  = done_q;
    assign dbg_state       = state_q;
endmodule

// File: tb/tb_multi_axis_tracker_ctrl.sv
// Bench for multi_axis_tracker_ctrl: directed scenarios plus randomized passes
// checked against a per-axis outcome model.
module tb_multi_axis_tracker_ctrl;
  import tracker_pkg::*;

  localparam int N      = 3;
  localparam int W      = 16;
  localparam int SETTLE = 8;
  localparam int MAXM   = 64;
  localparam int TSTART = 5;
  localparam int HALF   = 180;
  localparam logic [N-1:0] WRAP = 3'b010;
  localparam int BOUND  = 400;

  logic       clk;
  logic       rst;
  trk_state_t dbg_state;

  int checks = 0;
  int failures = 0;
  int pos_cnt[N];
  int neg_cnt[N];
  logic [15:0] exp_q[$];

  logic [N-1:0] any_mov;
  logic [N-1:0] sel_bit;
  logic         inv_ok;

  multi_axis_tracker_ctrl_if #(.N_AXES(N), .W(W)) bus ();

  multi_axis_tracker_ctrl #(
    .N_AXES(N), .W(W), .TOL_START(TSTART), .TOL_STOP(2), .HALF_TURN(HALF),
    .WRAP_MASK(WRAP), .SETTLE_CYC(SETTLE), .MAX_MOVE_CYC(MAXM)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus), .dbg_state(dbg_state)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // monitor: per-axis drive cycle counts and the one-drive-on-active-axis rule
  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < N; i++) begin
        if (bus.mov_pos[i]) pos_cnt[i]++;
        if (bus.mov_neg[i]) neg_cnt[i]++;
      end
      any_mov = bus.mov_pos | bus.mov_neg;
      sel_bit = N'(1) << bus.active_axis;
      inv_ok = ((bus.mov_pos & bus.mov_neg) == '0) && ((any_mov == '0) || (any_mov == sel_bit));
      checks++;
      assert (inv_ok === 1'b1) else begin
        failures++;
        $error("FAIL invariant observed pos=%b neg=%b axis=%0d expected one drive on active axis",
               bus.mov_pos, bus.mov_neg, bus.active_axis);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic clear_inputs();
    bus.sens_a = '0;
    bus.sens_b = '0;
    bus.pos_target = '0;
    bus.pos_actual = '0;
  endtask

  task automatic set_axis(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    bus.sens_a[i*W +: W] = a;
    bus.sens_b[i*W +: W] = b;
  endtask

  task automatic set_pos(input int i, input logic [W-1:0] t, input logic [W-1:0] p);
    bus.pos_target[i*W +: W] = t;
    bus.pos_actual[i*W +: W] = p;
  endtask

  task automatic do_reset(input logic mode);
    rst = 1'b1;
    bus.mode_manual = mode;
    clear_inputs();
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_eval(input int axis);
    int n;
    n = 0;
    while (!(dbg_state == ST_EVAL && int'(bus.active_axis) == axis) && n < BOUND) begin
      tick();
      n++;
    end
    check("eval_reached", 32'(n < BOUND), 1);
  endtask

  task automatic clear_counts();
    for (int i = 0; i < N; i++) begin
      pos_cnt[i] = 0;
      neg_cnt[i] = 0;
    end
  endtask

  initial begin
    int n;
    int a, b, t, p, e, mag, d, sel;
    logic mode;
    logic [N-1:0] exp_fault;

    // reset state
    rst = 1'b1;
    bus.mode_manual = 1'b0;
    clear_inputs();
    tick(); tick(); tick();
    check("rst_mov_pos", 32'(bus.mov_pos), 0);
    check("rst_mov_neg", 32'(bus.mov_neg), 0);
    check("rst_active", 32'(bus.active_axis), 0);
    check("rst_fault", 32'(bus.axis_fault), 0);
    check("rst_done", 32'(bus.cycle_done), 0);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));

    // automatic move on axis 0, stop at |err|=2, settle, advance
    set_axis(0, 600, 500);
    rst = 1'b0;
    tick();
    check("idle_to_eval", 32'(dbg_state), 32'(ST_EVAL));
    tick();
    check("auto_start", 32'(bus.mov_pos), 32'(3'b001));
    set_axis(0, 600, 550);
    tick();
    check("auto_ramp50", 32'(bus.mov_pos), 32'(3'b001));
    set_axis(0, 600, 597);
    tick();
    check("auto_err3_hold", 32'(bus.mov_pos), 32'(3'b001));
    set_axis(0, 600, 598);
    tick();
    check("auto_stop", 32'(bus.mov_pos), 0);
    check("auto_stop_state", 32'(dbg_state), 32'(ST_SETTLE));
    for (int i = 0; i < SETTLE; i++) tick();
    check("settle_len_state", 32'(dbg_state), 32'(ST_NEXT));
    check("settle_len_axis", 32'(bus.active_axis), 0);
    tick();
    check("next_axis", 32'(bus.active_axis), 1);

    // hysteresis on axis 0
    do_reset(1'b0);
    set_axis(0, 104, 100);
    tick(); tick();
    check("hys_err4_nomove", 32'(bus.mov_pos | bus.mov_neg), 0);
    check("hys_err4_state", 32'(dbg_state), 32'(ST_SETTLE));
    set_axis(0, 106, 100);
    wait_eval(0);
    tick();
    check("hys_err6_move", 32'(bus.mov_pos), 32'(3'b001));
    set_axis(0, 103, 100);
    tick(); tick(); tick();
    check("hys_err3_hold", 32'(bus.mov_pos), 32'(3'b001));
    set_axis(0, 102, 100);
    tick();
    check("hys_err2_stop", 32'(bus.mov_pos), 0);
    set_axis(0, 94, 100);
    wait_eval(0);
    tick();
    check("neg_move", 32'(bus.mov_neg), 32'(3'b001));
    check("neg_move_pos", 32'(bus.mov_pos), 0);
    rst = 1'b1;
    tick();
    check("rst_midmove", 32'(bus.mov_pos | bus.mov_neg), 0);
    check("rst_midmove_state", 32'(dbg_state), 32'(ST_IDLE));

    // no unsigned underflow: 0 - 3 is a small negative error
    do_reset(1'b0);
    set_axis(0, 0, 3);
    set_axis(1, 0, 6);
    tick(); tick();
    check("underflow_nomove", 32'(bus.mov_pos | bus.mov_neg), 0);
    wait_eval(1);
    tick();
    check("neg6_axis1", 32'(bus.mov_neg), 32'(3'b010));

    // manual mode: non-rotary axis 0 vs rotary axis 1, then mode abort
    do_reset(1'b1);
    set_pos(0, 350, 10);
    set_pos(1, 350, 10);
    tick(); tick();
    check("man_nonrot_pos", 32'(bus.mov_pos), 32'(3'b001));
    wait_eval(1);
    tick();
    check("man_rot_neg", 32'(bus.mov_neg), 32'(3'b010));
    check("man_rot_nopos", 32'(bus.mov_pos), 0);
    check("man_fault0", 32'(bus.axis_fault), 32'(3'b001));
    tick(); tick();
    bus.mode_manual = 1'b0;
    tick();
    check("abort_outputs", 32'(bus.mov_pos | bus.mov_neg), 0);
    check("abort_axis", 32'(bus.active_axis), 0);
    check("abort_state", 32'(dbg_state), 32'(ST_EVAL));
    check("abort_fault_kept", 32'(bus.axis_fault), 32'(3'b001));

    // timeout: exact move length, fault latch, skip on next pass
    do_reset(1'b0);
    set_axis(0, 200, 100);
    tick(); tick();
    check("to_start", 32'(bus.mov_pos), 32'(3'b001));
    n = 0;
    while (bus.mov_pos[0] && n < BOUND) begin
      n++;
      tick();
    end
    check("to_len", 32'(n), MAXM);
    check("to_fault", 32'(bus.axis_fault), 32'(3'b001));
    wait_eval(0);
    tick();
    check("to_skip", 32'(bus.mov_pos | bus.mov_neg), 0);
    check("to_skip_state", 32'(dbg_state), 32'(ST_SETTLE));

    // cycle_done period with all errors zero
    do_reset(1'b0);
    n = 0;
    while (!bus.cycle_done && n < BOUND) begin
      tick();
      n++;
    end
    check("done_first", 32'(n < BOUND), 1);
    tick();
    n = 1;
    while (!bus.cycle_done && n < BOUND) begin
      tick();
      n++;
    end
    check("done_period", 32'(n), N * (SETTLE + 2));

    // randomized passes: constant errors, so every move ends by timeout
    for (int it = 0; it < 8; it++) begin
      mode = it[0];
      do_reset(mode);
      exp_fault = '0;
      for (int i = 0; i < N; i++) begin
        if (!mode) begin
          if ($urandom_range(0, 3) == 0) begin
            a = int'($urandom_range(0, 65535));
            b = int'($urandom_range(0, 65535));
          end else begin
            b = int'($urandom_range(20, 1000));
            a = b + int'($urandom_range(0, 18)) - 9;
          end
          set_axis(i, 16'(a), 16'(b));
          e = a - b;
        end else begin
          p = int'($urandom_range(200, 1000));
          sel = int'($urandom_range(0, 5));
          case (sel)
            0: t = p - 181;
            1: t = p - 180;
            2: t = p + 180;
            3: t = p + 181;
            default: t = p + int'($urandom_range(0, 800)) - 400;
          endcase
          if (t < 0) t = 0;
          set_pos(i, 16'(t), 16'(p));
          e = t - p;
        end
        mag = (e < 0) ? -e : e;
        d = (e > 0) ? 1 : -1;
        if (mode && WRAP[i] && mag > HALF) d = -d;
        if (mag > TSTART) begin
          exp_fault[i] = 1'b1;
          exp_q.push_back((d > 0) ? 16'(MAXM) : 16'(0));
          exp_q.push_back((d < 0) ? 16'(MAXM) : 16'(0));
        end else begin
          exp_q.push_back(16'(0));
          exp_q.push_back(16'(0));
        end
      end
      exp_q.push_back(16'(exp_fault));
      clear_counts();
      n = 0;
      while (!bus.cycle_done && n < BOUND) begin
        tick();
        n++;
      end
      check("rnd_pass_done", 32'(n < BOUND), 1);
      for (int i = 0; i < N; i++) begin
        check("rnd_pos_cycles", 32'(pos_cnt[i]), 32'(exp_q.pop_front()));
        check("rnd_neg_cycles", 32'(neg_cnt[i]), 32'(exp_q.pop_front()));
      end
      check("rnd_fault", 32'(bus.axis_fault), 32'(exp_q.pop_front()));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
